// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave front end: oversampled deserialiser feeding the DAC frame parser,
// with a byte-wide MISO return path loaded from tx_data.
module spi_slave_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_TX     = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rxd_out,
  output logic       rxd_flag,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       frame_err,
  output logic       spi_active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0]   rx_shift, rx_shift_nxt;
  logic [BYTE_W-1:0]   tx_shift, tx_shift_nxt;
  logic [BYTE_W-1:0]   rxd_out_nxt;
  logic                rxd_flag_nxt, tx_load_nxt, frame_err_nxt, spi_miso_nxt;

  // Synchronisers reset to 0 so WAIT_IDLE only leaves on a genuine CS-high level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rxd_out     <= '0;
      rxd_flag    <= 1'b0;
      tx_load     <= 1'b0;
      frame_err   <= 1'b0;
      spi_active  <= 1'b0;
      spi_miso    <= IDLE_TX[7];
      spi_miso_oe <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      rx_shift    <= rx_shift_nxt;
      tx_shift    <= tx_shift_nxt;
      rxd_out     <= rxd_out_nxt;
      rxd_flag    <= rxd_flag_nxt;
      tx_load     <= tx_load_nxt;
      frame_err   <= frame_err_nxt;
      spi_active  <= (state_nxt == ACTIVE);
      spi_miso    <= spi_miso_nxt;
      spi_miso_oe <= (state_nxt == ACTIVE);
    end
  end

  // CS release is checked before SCK edges so a coincident rise is dropped.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    rx_shift_nxt  = rx_shift;
    tx_shift_nxt  = tx_shift;
    rxd_out_nxt   = rxd_out;
    rxd_flag_nxt  = 1'b0;
    tx_load_nxt   = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (cs_s) state_nxt = IDLE;
      end
      IDLE: begin
        if (!cs_s) begin
          state_nxt    = ACTIVE;
          tx_shift_nxt = tx_data;
          tx_load_nxt  = 1'b1;
          bit_cnt_nxt  = '0;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_nxt     = IDLE;
          bit_cnt_nxt   = '0;
          frame_err_nxt = (bit_cnt != '0);
        end else if (sck_rise) begin
          rx_shift_nxt = {rx_shift[BYTE_W-2:0], mosi_s};
          bit_cnt_nxt  = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(7)) begin
            rxd_out_nxt  = {rx_shift[BYTE_W-2:0], mosi_s};
            rxd_flag_nxt = 1'b1;
            bit_cnt_nxt  = '0;
            tx_shift_nxt = tx_data;
            tx_load_nxt  = 1'b1;
          end
        end else if (sck_fall && (bit_cnt != '0)) begin
          // The fall right after a byte boundary keeps the fresh MSB on MISO.
          tx_shift_nxt = {tx_shift[BYTE_W-2:0], 1'b0};
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
    spi_miso_nxt = (state_nxt == ACTIVE) ? tx_shift_nxt[BYTE_W-1] : IDLE_TX[7];
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: SPI master at clk/8, pulse counters and a received-byte log.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rxd_out;
  logic       rxd_flag;
  logic [7:0] tx_data;
  logic       tx_load, frame_err, spi_active;

  int checks = 0;
  int errors = 0;
  int n_flag = 0, n_load = 0, n_ferr = 0;
  bit flag_prev = 1'b0, flag_consec = 1'b0;
  logic [7:0] rx_q[$];

  spi_slave_rx #(.SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rxd_out(rxd_out), .rxd_flag(rxd_flag),
    .tx_data(tx_data), .tx_load(tx_load),
    .frame_err(frame_err), .spi_active(spi_active)
  );

  always #5 clk = ~clk;

  // Pulse counters and byte log, sampled away from the active edge.
  always @(negedge clk) begin
    if (rxd_flag) begin
      n_flag++;
      rx_q.push_back(rxd_out);
      if (flag_prev) flag_consec = 1'b1;
    end
    flag_prev = rxd_flag;
    if (tx_load) n_load++;
    if (frame_err) n_ferr++;
  end

  // All SPI helpers start and end on a falling clk edge.
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (4) @(negedge clk);
    m = spi_miso;
    spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] m);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], m[i]);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; tx_data = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({rxd_out, rxd_flag, tx_load, frame_err, spi_active, spi_miso, spi_miso_oe} !== {8'h00, 6'b000010}) begin
      errors++;
      $display("FAIL reset_state: rxd_out=%h flag=%b load=%b ferr=%b act=%b miso=%b oe=%b, required 00 0 0 0 0 1 0",
               rxd_out, rxd_flag, tx_load, frame_err, spi_active, spi_miso, spi_miso_oe);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single_latency();
    logic m;
    int f0, e0;
    f0 = n_flag; e0 = n_ferr;
    cs_low();
    for (int i = 7; i >= 1; i--) spi_bit(1'(8'h5A >> i), m);
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    spi_sck = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (rxd_flag !== 1'b0) begin
      errors++; $display("FAIL latency_early: rxd_flag=%b, required 0", rxd_flag);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rxd_flag !== 1'b1 || rxd_out !== 8'h5A) begin
      errors++; $display("FAIL latency_edge: rxd_flag=%b rxd_out=%h, required 1 5a", rxd_flag, rxd_out);
    end
    repeat (3) @(negedge clk);
    spi_sck = 1'b0;
    cs_high();
    checks++;
    if (n_flag - f0 != 1 || n_ferr - e0 != 0 || rxd_out !== 8'h5A) begin
      errors++;
      $display("FAIL single_byte: flags=%0d ferr=%0d rxd_out=%h, required 1 0 5a", n_flag - f0, n_ferr - e0, rxd_out);
    end
  endtask

  task automatic test_stream();
    logic [7:0] bytes[7] = '{8'h5A, 8'h10, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    logic [7:0] m;
    int f0, l0;
    f0 = n_flag; l0 = n_load;
    rx_q.delete();
    cs_low();
    foreach (bytes[i]) spi_byte(bytes[i], m);
    cs_high();
    checks++;
    if (n_flag - f0 != 7 || n_load - l0 != 8) begin
      errors++;
      $display("FAIL stream_counts: flags=%0d loads=%0d, required 7 8", n_flag - f0, n_load - l0);
    end
    foreach (bytes[i]) begin
      checks++;
      if (rx_q.size() <= i || rx_q[i] !== bytes[i]) begin
        errors++;
        $display("FAIL stream_byte%0d: got %h, required %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, bytes[i]);
      end
    end
  endtask

  task automatic test_miso();
    logic [7:0] m0, m1;
    logic m;
    tx_data = 8'hC3;
    @(negedge clk);
    checks++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b1) begin
      errors++; $display("FAIL miso_idle: oe=%b miso=%b, required 0 1", spi_miso_oe, spi_miso);
    end
    cs_low();
    for (int i = 7; i >= 0; i--) begin
      spi_bit(1'b0, m);
      m0[i] = m;
      if (i == 4) begin
        tx_data = 8'h3C;
        checks++;
        if (spi_miso_oe !== 1'b1) begin
          errors++; $display("FAIL miso_oe_active: oe=%b, required 1", spi_miso_oe);
        end
      end
    end
    tx_data = 8'h55;
    spi_byte(8'h00, m1);
    cs_high();
    checks++;
    if (m0 !== 8'hC3) begin
      errors++; $display("FAIL miso_byte0: got %h, required c3", m0);
    end
    checks++;
    if (m1 !== 8'h3C) begin
      errors++; $display("FAIL miso_byte1: got %h, required 3c", m1);
    end
    checks++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b1) begin
      errors++; $display("FAIL miso_release: oe=%b miso=%b, required 0 1", spi_miso_oe, spi_miso);
    end
    tx_data = 8'h00;
  endtask

  task automatic test_frame_err();
    logic m;
    logic [7:0] mb;
    int f0, e0;
    f0 = n_flag; e0 = n_ferr;
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    cs_high();
    checks++;
    if (n_flag - f0 != 0 || n_ferr - e0 != 1) begin
      errors++; $display("FAIL partial_byte: flags=%0d ferr=%0d, required 0 1", n_flag - f0, n_ferr - e0);
    end
    cs_low();
    spi_byte(8'h81, mb);
    cs_high();
    checks++;
    if (n_flag - f0 != 1 || n_ferr - e0 != 1 || rxd_out !== 8'h81) begin
      errors++;
      $display("FAIL after_partial: flags=%0d ferr=%0d rxd_out=%h, required 1 1 81", n_flag - f0, n_ferr - e0, rxd_out);
    end
  endtask

  task automatic test_reset_mid();
    logic m;
    logic [7:0] mb;
    int f0, e0;
    cs_low();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    f0 = n_flag; e0 = n_ferr;
    for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
    checks++;
    if (n_flag - f0 != 0 || n_ferr - e0 != 0 || spi_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: flags=%0d ferr=%0d active=%b, required 0 0 0", n_flag - f0, n_ferr - e0, spi_active);
    end
    cs_high();
    checks++;
    if (n_flag - f0 != 0 || n_ferr - e0 != 0) begin
      errors++; $display("FAIL reset_mid_cs: flags=%0d ferr=%0d, required 0 0", n_flag - f0, n_ferr - e0);
    end
    cs_low();
    spi_byte(8'h3C, mb);
    cs_high();
    checks++;
    if (n_flag - f0 != 1 || rxd_out !== 8'h3C) begin
      errors++; $display("FAIL reset_mid_byte: flags=%0d rxd_out=%h, required 1 3c", n_flag - f0, rxd_out);
    end
  endtask

  task automatic test_idle_sck();
    int f0, l0, e0;
    bit act_seen = 1'b0;
    f0 = n_flag; l0 = n_load; e0 = n_ferr;
    for (int i = 0; i < 16; i++) begin
      spi_mosi = 1'(i);
      repeat (4) @(negedge clk);
      spi_sck = ~spi_sck;
      if (spi_active) act_seen = 1'b1;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (n_flag - f0 != 0 || n_load - l0 != 0 || n_ferr - e0 != 0 || act_seen) begin
      errors++;
      $display("FAIL idle_sck: flags=%0d loads=%0d ferr=%0d active_seen=%b, required 0 0 0 0",
               n_flag - f0, n_load - l0, n_ferr - e0, act_seen);
    end
  endtask

  task automatic test_back_to_back();
    checks++;
    if (flag_consec) begin
      errors++; $display("FAIL flag_spacing: consecutive rxd_flag=%b, required 0", flag_consec);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_stream();
    test_miso();
    test_frame_err();
    test_reset_mid();
    test_idle_sck();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
